// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch predictor
package bp_pkg;

   // 2-bit direction counter encoding
   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;

   // Counter value after reset and on a fresh allocation
   localparam logic [1:0] CTR_RESET = CTR_WNT;
   localparam logic [1:0] CTR_ALLOC = CTR_WT;

   // Reset-managed part of a BTB entry; tag and target live in separate
   // non-reset arrays sized by the top-level parameters.
   typedef struct packed {
      logic       valid;
      logic [1:0] ctr;
   } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, EX training and perf counter bundle
interface branch_predictor_if #(
   parameter int PCLEN = 32
);
   logic [PCLEN-1:0] F_pc_va;
   logic [PCLEN-1:0] F_BP_target_pc;
   logic             F_BP_pred_taken;
   logic             EX_br_valid;
   logic [PCLEN-1:0] EX_br_pc;
   logic             EX_br_taken;
   logic [PCLEN-1:0] EX_br_target;
   logic             EX_mispredict;
   logic [31:0]      perf_br_cnt;
   logic [31:0]      perf_mispred_cnt;

   // Pipeline side: presents the fetch PC and resolved branches
   modport master (
      output F_pc_va, EX_br_valid, EX_br_pc, EX_br_taken, EX_br_target, EX_mispredict,
      input  F_BP_target_pc, F_BP_pred_taken, perf_br_cnt, perf_mispred_cnt
   );

   // Predictor side
   modport slave (
      input  F_pc_va, EX_br_valid, EX_br_pc, EX_br_taken, EX_br_target, EX_mispredict,
      output F_BP_target_pc, F_BP_pred_taken, perf_br_cnt, perf_mispred_cnt
   );
endinterface

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - 2-bit saturating direction counter next-state function
module bp_sat_ctr
   import bp_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);

   // Move toward the outcome, holding at the strong ends
   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and perf counters
module branch_predictor
   import bp_pkg::*;
#(
   parameter  int PCLEN       = 32,
   parameter  int BTB_ENTRIES = 16,
   localparam int IDX_BITS    = $clog2(BTB_ENTRIES),
   localparam int TAG_BITS    = PCLEN - IDX_BITS - 2
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bus
);

   btb_entry_t          r_ent    [BTB_ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [BTB_ENTRIES];
   logic [PCLEN-1:0]    r_target [BTB_ENTRIES];
   logic [31:0]         r_perf_br;
   logic [31:0]         r_perf_mispred;

   logic [IDX_BITS-1:0] w_f_idx;
   logic [TAG_BITS-1:0] w_f_tag;
   logic                w_f_hit;
   logic                w_f_taken;
   logic [IDX_BITS-1:0] w_u_idx;
   logic [TAG_BITS-1:0] w_u_tag;
   logic                w_u_hit;
   logic [1:0]          w_ctr_next;
   logic                w_unused_lowbits;

   // Byte-offset bits never participate in index or tag
   assign w_unused_lowbits = ^{bus.F_pc_va[1:0], bus.EX_br_pc[1:0]};

   assign w_f_idx = bus.F_pc_va[IDX_BITS+1:2];
   assign w_f_tag = bus.F_pc_va[PCLEN-1:IDX_BITS+2];
   assign w_u_idx = bus.EX_br_pc[IDX_BITS+1:2];
   assign w_u_tag = bus.EX_br_pc[PCLEN-1:IDX_BITS+2];

   // Zero-latency lookup; reads the pre-update entry, no bypass from EX
   assign w_f_hit   = r_ent[w_f_idx].valid && (r_tag[w_f_idx] == w_f_tag);
   assign w_f_taken = w_f_hit && r_ent[w_f_idx].ctr[1];
   assign w_u_hit   = r_ent[w_u_idx].valid && (r_tag[w_u_idx] == w_u_tag);

   assign bus.F_BP_pred_taken  = w_f_taken;
   assign bus.F_BP_target_pc   = w_f_taken ? r_target[w_f_idx] : bus.F_pc_va + PCLEN'(4);
   assign bus.perf_br_cnt      = r_perf_br;
   assign bus.perf_mispred_cnt = r_perf_mispred;

   bp_sat_ctr u_sat_ctr (
      .ctr      (r_ent[w_u_idx].ctr),
      .taken    (bus.EX_br_taken),
      .ctr_next (w_ctr_next)
   );

   // Valid/counter training and perf counting; reset wipes predictions at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            r_ent[i] <= '{valid: 1'b0, ctr: CTR_RESET};
         end
         r_perf_br      <= 32'd0;
         r_perf_mispred <= 32'd0;
      end else if (bus.EX_br_valid) begin
         r_perf_br <= r_perf_br + 32'd1;
         if (bus.EX_mispredict) r_perf_mispred <= r_perf_mispred + 32'd1;
         if (w_u_hit) begin
            r_ent[w_u_idx].ctr <= w_ctr_next;
         end else if (bus.EX_br_taken) begin
            r_ent[w_u_idx] <= '{valid: 1'b1, ctr: CTR_ALLOC};
         end
      end
   end

   // Tag/target capture on every taken resolution; on a hit the tag rewrite is a no-op
   always_ff @(posedge clk) begin
      if (bus.EX_br_valid && bus.EX_br_taken) begin
         r_tag[w_u_idx]    <= w_u_tag;
         r_target[w_u_idx] <= bus.EX_br_target;
      end
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor that computes `F_BP_target_pc`, the next sequential/predicted PC consumed by the PC register every non-stalled, non-redirected cycle. It combines a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating direction counters. It is trained from the EX stage when a branch or jump resolves, and keeps two performance counters for branch and mispredict statistics.

## Interface
Parameters:
- `PCLEN`, 32, PC width in bits.
- `BTB_ENTRIES`, 16, number of BTB entries; must be a power of two and at least 2.
- `IDX_BITS`, `$clog2(BTB_ENTRIES)`, derived index width; not overridden.
- `TAG_BITS`, `PCLEN-IDX_BITS-2`, derived tag width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `F_pc_va`  in  PCLEN  current fetch PC from the PC register.
- `F_BP_target_pc`  out  PCLEN  predicted next fetch PC.
- `F_BP_pred_taken`  out  1  prediction is taken (BTB hit and counter bit 1 set).
- `EX_br_valid`  in  1  a branch or jump resolves in EX this cycle.
- `EX_br_pc`  in  PCLEN  PC of the resolving instruction.
- `EX_br_taken`  in  1  actual outcome.
- `EX_br_target`  in  PCLEN  actual target; meaningful only when `EX_br_taken`=1.
- `EX_mispredict`  in  1  EX detected a wrong prediction; sampled only when `EX_br_valid`=1.
- `perf_br_cnt`  out  32  count of resolved branches.
- `perf_mispred_cnt`  out  32  count of mispredicts.

## Operation
Address split:
- Index = `pc[IDX_BITS+1:2]`.
- Tag = `pc[PCLEN-1:IDX_BITS+2]`.
- `pc[1:0]` is ignored everywhere.

Entry state: `valid`, `tag`, `target[PCLEN-1:0]`, `ctr[1:0]`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Lookup (combinational, from `F_pc_va`):
- Hit = `valid` set and stored tag equals the fetch tag.
- `F_BP_pred_taken` = hit & `ctr[1]`.
- `F_BP_target_pc` = entry target if `F_BP_pred_taken`=1, else `F_pc_va + 4`, modulo 2^PCLEN (wraps to 0 at the top of the address space).

Update (clocked, when `EX_br_valid`=1):
- Hit on `EX_br_pc`, taken: `ctr` saturating-increments (11 stays 11); target overwritten with `EX_br_target`.
- Hit, not taken: `ctr` saturating-decrements (00 stays 00); target unchanged.
- Miss, taken: allocate (overwriting any aliasing entry): `valid`=1, tag written, target = `EX_br_target`, `ctr`=10.
- Miss, not taken: no state change.

Perf counters:
- `perf_br_cnt` increments when `EX_br_valid`=1.
- `perf_mispred_cnt` increments when `EX_br_valid` & `EX_mispredict`.
- Both are 32-bit and wrap from 0xFFFFFFFF to 0.

Reset clears every `valid` bit, sets every `ctr` to 01, and clears both perf counters. Target and tag contents are don't-care after reset.

## Timing
- Lookup latency is 0 cycles: `F_BP_target_pc` is valid in the same cycle as `F_pc_va`, so the PC register can load it at the next edge.
- An update in cycle N is visible to lookups from cycle N+1. A same-cycle lookup and update on the same index returns the pre-update entry; there is no bypass.
- `stall_D` and the EX redirect are handled by the PC register. The predictor always trains on `EX_br_valid` regardless of stall.
- Reset asserted mid-operation clears state immediately (asynchronously). An update presented while `rst`=1 is discarded.
- Reset values:
  - `F_BP_pred_taken`=0.
  - `F_BP_target_pc` = `F_pc_va + 4`.
  - Both perf counters = 0.

## Structure
- Package `bp_pkg` holds:
  - Counter encoding localparams (`CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`).
  - `CTR_RESET` (= `CTR_WNT`) and `CTR_ALLOC` (= `CTR_WT`).
  - Entry struct typedef `btb_entry_t`.
- Sub-module `bp_sat_ctr`: pure combinational next-state function for the 2-bit counter, taking `ctr` and `taken` and producing `ctr_next`.
- BTB storage is flop arrays. Valid bits and counters are reset; tags and targets are not.

## Test plan
- Reset then `F_pc_va`=0x100 → `F_BP_target_pc`=0x104, `F_BP_pred_taken`=0; both perf counters read 0.
- Taken update pc=0x100, target=0x200; next cycle `F_pc_va`=0x100 → `F_BP_target_pc`=0x200, `F_BP_pred_taken`=1.
- Two not-taken updates on 0x100 (ctr 10→01→00) → prediction 0x104; three taken updates → ctr saturates at 11 and stays there after a further taken update.
- Alias with `BTB_ENTRIES`=16: taken update pc=0x140 (same index as 0x100) replaces the 0x100 entry → lookup 0x100 returns 0x104; lookup 0x140 returns the new target.
- Same-cycle lookup and update on 0x300 → the same cycle returns 0x304; the next cycle returns the trained target. `F_pc_va`=0xFFFFFFFC with a miss → 0x00000000.
- 5 updates with `EX_mispredict`=1 on 2 of them → `perf_br_cnt`=5, `perf_mispred_cnt`=2. Asserting `rst` mid-sequence zeroes both counters immediately, and the predictor falls back to pc+4.
